// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and constants for the UART transmit path.
//                Holds the transmitter state encoding, the parity mode
//                encoding, the default bit-period divisor and the helpers
//                that decode the parity select and compute a parity bit.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_t;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10
    } uart_parity_t;

    // 100 MHz system clock / 9600 baud
    localparam int UART_DEFAULT_DIVISOR = 10416;

    // Select code 2'b11 is reserved and behaves as "no parity".
    function automatic uart_parity_t decode_parity(input logic [1:0] sel);
        case (sel)
            2'b01:   return PAR_EVEN;
            2'b10:   return PAR_ODD;
            default: return PAR_NONE;
        endcase
    endfunction

    // Words narrower than 8 bits are zero-extended by the caller; the
    // extra zeros do not change the XOR.
    function automatic logic calc_parity(input logic [7:0] data, input uart_parity_t mode);
        return (^data) ^ (mode == PAR_ODD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_param_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_param_if
//  Description : Word-level handshake between a transmit data source and
//                the UART transmitter.
//                  tx_valid   : source has a word on tx_data
//                  tx_ready   : transmitter can accept a word (IDLE only)
//                  tx_data    : DATA_BITS-wide word, captured at accept
//                  parity_sel : per-frame parity mode, captured at accept
//                master = data source, slave = transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_param_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8
);
    logic                 tx_valid;
    logic                 tx_ready;
    logic [DATA_BITS-1:0] tx_data;
    logic [1:0]           parity_sel;

    modport master (
        output tx_valid,
        output tx_data,
        output parity_sel,
        input  tx_ready
    );

    modport slave (
        input  tx_valid,
        input  tx_data,
        input  parity_sel,
        output tx_ready
    );

endinterface
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
//  Module      : uart_baud_gen
//  Description : Bit-period counter shared by the UART transmitter and
//                receiver. Counts 0..DIVISOR-1 while enabled and raises
//                tick on the last cycle of every bit period.
//  Ports       : clk   - clock, rising edge
//                reset - synchronous, active-low
//                clr   - restart the bit period (counter to 0)
//                en    - count; when low the counter holds its value
//                tick  - last cycle of the current bit period
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int DIVISOR = UART_DEFAULT_DIVISOR
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int            CW     = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(DIVISOR - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= (r_cnt == C_LAST) ? '0 : r_cnt + CW'(1);
        end
    end

    assign tick = en && !clr && (r_cnt == C_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_tx_param.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_param
//  Description : Parametrised UART transmitter. Accepts one word per
//                valid/ready handshake and sends it LSB first framed by a
//                start bit, an optional parity bit and STOP_BITS stop bits.
//  Ports       : clk     - clock, rising edge
//                reset   - synchronous, active-low
//                bus     - slave side of uart_tx_param_if
//                          (tx_valid, tx_ready, tx_data, parity_sel)
//                TxD     - serial line, idle high
//                tx_busy - frame in progress
//                tx_done - one-cycle pulse after the last stop bit
//  Config      : `UART_TX_PARITY_EN - when defined, the PARITY state is
//                built and parity_sel is honoured; otherwise every frame is
//                sent without parity and parity_sel is ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DIVISOR   = UART_DEFAULT_DIVISOR,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic            clk,
    input  logic            reset,
    uart_tx_param_if.slave  bus,
    output logic            TxD,
    output logic            tx_busy,
    output logic            tx_done
);

    localparam int             BCW         = $clog2(DATA_BITS + 1);
    localparam logic [BCW-1:0] C_LAST_DATA = BCW'(DATA_BITS - 1);
    localparam logic [BCW-1:0] C_LAST_STOP = BCW'(STOP_BITS - 1);

    uart_tx_state_t       r_state,   w_state_next;
    logic [DATA_BITS-1:0] r_shift,   w_shift_next;
    logic [BCW-1:0]       r_bit_cnt, w_bit_cnt_next;
    logic                 r_txd,     w_txd_next;
    logic                 r_ready;
    logic                 r_busy;
    logic                 r_done,    w_done_next;
    logic                 w_accept;
    logic                 w_tick;

    // r_ready is high exactly when the FSM is in IDLE, so the accept term
    // never feeds tx_ready back combinationally.
    assign w_accept = bus.tx_valid & r_ready;

    // Restarting the counter at accept makes the start bit a full period
    // regardless of where the counter was left.
    uart_baud_gen #(
        .DIVISOR (DIVISOR)
    ) u_baud_gen (
        .clk   (clk),
        .reset (reset),
        .clr   (w_accept),
        .en    (r_state != IDLE),
        .tick  (w_tick)
    );

`ifdef UART_TX_PARITY_EN
    logic r_par_en;
    logic r_par_bit;

    // Parity is fixed at accept from the word being sent, so later changes
    // on tx_data/parity_sel cannot corrupt the frame in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
        end else if (w_accept) begin
            r_par_en  <= (decode_parity(bus.parity_sel) != PAR_NONE);
            r_par_bit <= calc_parity(8'(bus.tx_data), decode_parity(bus.parity_sel));
        end
    end
`else
    logic w_unused_parity_sel;
    assign w_unused_parity_sel = ^bus.parity_sel;
`endif

    // Next-state and next-output logic. TxD is registered, so the value
    // for the state being entered is computed here.
    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_bit_cnt_next = r_bit_cnt;
        w_txd_next     = r_txd;
        w_done_next    = 1'b0;

        case (r_state)
            IDLE: begin
                w_txd_next = 1'b1;
                if (w_accept) begin
                    w_state_next = START;
                    w_shift_next = bus.tx_data;
                    w_txd_next   = 1'b0;
                end
            end

            START: begin
                if (w_tick) begin
                    w_state_next   = DATA;
                    w_bit_cnt_next = '0;
                    w_txd_next     = r_shift[0];
                end
            end

            DATA: begin
                if (w_tick) begin
                    if (r_bit_cnt == C_LAST_DATA) begin
                        w_state_next   = STOP;
                        w_bit_cnt_next = '0;
                        w_txd_next     = 1'b1;
`ifdef UART_TX_PARITY_EN
                        if (r_par_en) begin
                            w_state_next = PARITY;
                            w_txd_next   = r_par_bit;
                        end
`endif
                    end else begin
                        w_shift_next   = r_shift >> 1;
                        w_bit_cnt_next = r_bit_cnt + BCW'(1);
                        w_txd_next     = w_shift_next[0];
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (w_tick) begin
                    w_state_next   = STOP;
                    w_bit_cnt_next = '0;
                    w_txd_next     = 1'b1;
                end
            end
`endif

            STOP: begin
                w_txd_next = 1'b1;
                if (w_tick) begin
                    if (r_bit_cnt == C_LAST_STOP) begin
                        w_state_next = IDLE;
                        w_done_next  = 1'b1;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + BCW'(1);
                    end
                end
            end

            default: begin
                w_state_next = IDLE;
                w_txd_next   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_txd     <= 1'b1;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_shift   <= w_shift_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_txd     <= w_txd_next;
            r_ready   <= (w_state_next == IDLE);
            r_busy    <= (w_state_next != IDLE);
            r_done    <= w_done_next;
        end
    end

    assign bus.tx_ready = r_ready;
    assign TxD          = r_txd;
    assign tx_busy      = r_busy;
    assign tx_done      = r_done;

endmodule
`default_nettype wire
